// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator for the data Memory block.
// Define MISALIGN_TRAP_EN to trap misaligned accesses instead of splitting.
module mem_access_unit #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [1:0]        mode,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACC, S_RD0, S_RD1,
    S_WR0, S_WR1, S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       lo_q, lo_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              mis_in;
  logic [ADDR_W-3:0] wd0, wd1;
  logic [ADDR_W-1:0] wa0, wa1;
  logic [4:0]        shamt;
  logic [31:0]       szmask;
  logic [63:0]       mask64, dat64, merged, ld64;

  function automatic logic [31:0] extend(
    input logic [31:0] v,
    input logic [1:0]  sz,
    input logic        u
  );
    logic [31:0] r;
    r = v;
    unique case (sz)
      2'b00:   r = {{24{v[7] & ~u}}, v[7:0]};
      2'b01:   r = {{16{v[15] & ~u}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  assign mis_in =
    (req_size == 2'b01 && req_addr[1:0] == 2'b11) ||
    (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  // the two word slots straddled by a split access; upper one wraps
  assign wd0 = addr_q[ADDR_W-1:2];
  assign wd1 = wd0 + {{(ADDR_W-3){1'b0}}, 1'b1};
  assign wa0 = {wd0, 2'b00};
  assign wa1 = {wd1, 2'b00};
  assign shamt = {addr_q[1:0], 3'b000};

  // byte lanes of the 64-bit pair covered by the store
  always_comb begin
    szmask = 32'hFFFF_FFFF;
    unique case (size_q)
      2'b00:   szmask = 32'h0000_00FF;
      2'b01:   szmask = 32'h0000_FFFF;
      default: szmask = 32'hFFFF_FFFF;
    endcase
  end

  assign mask64 = {32'd0, szmask} << shamt;
  assign dat64  = {32'd0, wdata_q} << shamt;
  assign merged = ({hi_q, lo_q} & ~mask64) | (dat64 & mask64);
  assign ld64   = {data_out, lo_q} >> shamt;

  // state and request registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // next state, memory bus drive and response outputs
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    mode      = 2'b00;
    addr      = '0;
    data_in   = '0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          lo_d    = '0;
          hi_d    = '0;
          rdata_d = '0;
          err_d   = 1'b0;
          if (req_size == 2'b11) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (mis_in) begin
`ifdef MISALIGN_TRAP_EN
            err_d   = 1'b1;
            state_d = S_RESP;
`else
            state_d = S_RD0;
`endif
          end else begin
            state_d = S_ACC;
          end
        end
      end
      S_ACC: begin
        mode = size_q;
        addr = addr_q;
        if (we_q) begin
          MemWrite = 1'b1;
          data_in  = wdata_q;
        end else begin
          MemRead = 1'b1;
          rdata_d = extend(data_out, size_q, uns_q);
        end
        state_d = S_RESP;
      end
`ifndef MISALIGN_TRAP_EN
      S_RD0: begin
        MemRead = 1'b1;
        mode    = 2'b10;
        addr    = wa0;
        lo_d    = data_out;
        state_d = S_RD1;
      end
      S_RD1: begin
        MemRead = 1'b1;
        mode    = 2'b10;
        addr    = wa1;
        hi_d    = data_out;
        if (we_q) begin
          state_d = S_WR0;
        end else begin
          rdata_d = extend(ld64[31:0], size_q, uns_q);
          state_d = S_RESP;
        end
      end
      S_WR0: begin
        MemWrite = 1'b1;
        mode     = 2'b10;
        addr     = wa0;
        data_in  = merged[31:0];
        state_d  = S_WR1;
      end
      S_WR1: begin
        MemWrite = 1'b1;
        mode     = 2'b10;
        addr     = wa1;
        data_in  = merged[63:32];
        state_d  = S_RESP;
      end
`endif
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench with a byte-array Memory model.
// Reference model works on whole requests, not on bus cycles.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  mode;
  logic [5:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .mode(mode), .addr(addr),
    .data_in(data_in), .data_out(data_out)
  );

  // Memory block: byte array, combinational read, wraps mod 64
  logic [7:0] mem [64];

  always_comb begin
    data_out = '0;
    for (int i = 0; i < 4; i++)
      if (i < (1 << mode))
        data_out[8*i +: 8] = mem[6'(int'(addr) + i)];
  end

  always @(posedge clk) begin
    if (MemWrite)
      for (int i = 0; i < 4; i++)
        if (i < (1 << mode))
          mem[6'(int'(addr) + i)] <= data_in[8*i +: 8];
  end

  // reference model state and scoreboard queues
  typedef struct {
    bit [31:0] rdata;
    bit        err;
    int        lat;
  } rsp_t;

  typedef struct {
    bit        we;
    bit [1:0]  mode;
    bit [5:0]  a;
    bit [31:0] d;
  } bus_t;

  bit [7:0] ref_mem [64];
  rsp_t     exp_q[$];
  bus_t     bus_q[$];
  int       checks = 0;
  int       errors = 0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] ext(bit [31:0] v, int nb, bit u);
    bit [31:0] r;
    r = v;
    if (nb == 1 && !u && v[7])  r = v | 32'hFFFF_FF00;
    if (nb == 2 && !u && v[15]) r = v | 32'hFFFF_0000;
    return r;
  endfunction

  function automatic bit [31:0] ref_word(bit [5:0] w);
    bit [31:0] r;
    r = 0;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = ref_mem[6'(int'(w) + i)];
    return r;
  endfunction

  function automatic bus_t mk_bus(bit we, bit [1:0] m, bit [5:0] a,
                                  bit [31:0] d);
    bus_t b;
    b.we = we; b.mode = m; b.a = a; b.d = d;
    return b;
  endfunction

  task automatic wait_ready();
    int t;
    t = 0;
    while (!req_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got 0 expected 1 at %0t", $time);
    end
  endtask

  task automatic drive(bit we, bit [1:0] sz, bit u, bit [5:0] a,
                       bit [31:0] wd);
    wait_ready();
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = wd;
    @(posedge clk); #1;
    req_valid    = 1'b0;
  endtask

  // model one request from the byte-level rules, then issue it
  task automatic issue(bit we, bit [1:0] sz, bit u, bit [5:0] a,
                       bit [31:0] wd);
    rsp_t      r;
    int        nb;
    bit        mis;
    bit [5:0]  w0, w1;
    bit [31:0] v;
    nb  = 1 << sz;
    mis = (sz == 2'd1 && a[1:0] == 2'd3) ||
          (sz == 2'd2 && a[1:0] != 2'd0);
    r.rdata = 0;
    r.err   = 0;
    r.lat   = 0;
    if (sz == 2'd3) begin
      r.err = 1;
      r.lat = 1;
    end
`ifdef MISALIGN_TRAP_EN
    else if (mis) begin
      r.err = 1;
      r.lat = 1;
    end
`endif
    else begin
      v = 0;
      for (int i = 0; i < nb; i++)
        v |= 32'(ref_mem[6'(int'(a) + i)]) << (8 * i);
      if (we) begin
        for (int i = 0; i < nb; i++)
          ref_mem[6'(int'(a) + i)] = wd[8*i +: 8];
      end else begin
        r.rdata = ext(v, nb, u);
      end
      if (!mis) begin
        bus_q.push_back(mk_bus(we, sz, a, we ? wd : 32'd0));
        r.lat = 2;
      end else begin
        w0 = {a[5:2], 2'b00};
        w1 = w0 + 6'd4;
        bus_q.push_back(mk_bus(1'b0, 2'd2, w0, 32'd0));
        bus_q.push_back(mk_bus(1'b0, 2'd2, w1, 32'd0));
        if (we) begin
          bus_q.push_back(mk_bus(1'b1, 2'd2, w0, ref_word(w0)));
          bus_q.push_back(mk_bus(1'b1, 2'd2, w1, ref_word(w1)));
        end
        r.lat = we ? 5 : 3;
      end
    end
    exp_q.push_back(r);
    drive(we, sz, u, a, wd);
  endtask

  // monitor: compares bus cycles and responses against the queues
  int k = 0;
  int acc_k = 0;

  initial begin
    bus_t b;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (MemRead && MemWrite) begin
          checks++; errors++;
          $display("FAIL bus_both: got 11 expected not both");
        end
        if (MemRead || MemWrite) begin
          if (bus_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL bus_unexpected: got addr %h expected none", addr);
          end else begin
            b = bus_q.pop_front();
            chk("bus_we", 32'(MemWrite), 32'(b.we));
            chk("bus_mode", 32'(mode), 32'(b.mode));
            chk("bus_addr", 32'(addr), 32'(b.a));
            if (b.we) chk("bus_data", data_in, b.d);
          end
        end
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp_unexpected: got %h expected none", rsp_rdata);
          end else begin
            r = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, r.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(r.err));
            chk("rsp_latency", 32'(k - acc_k), 32'(r.lat));
          end
        end
        if (req_valid && req_ready) acc_k = k;
      end
      k++;
    end
  end

  // abort a misaligned store at its first write cycle
  task automatic abort_store();
    int t;
    bus_q.push_back(mk_bus(1'b0, 2'd2, 6'd0, 32'd0));
    bus_q.push_back(mk_bus(1'b0, 2'd2, 6'd4, 32'd0));
    drive(1'b1, 2'd2, 1'b0, 6'd3, 32'h1234_5678);
    t = 0;
    while (!MemWrite && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("abort_reached_wr0", 32'(MemWrite), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_memwrite", 32'(MemWrite), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
  endtask

  initial begin
    int t;
    rst          = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    #12;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_memread", 32'(MemRead), 32'd0);
    chk("rst_memwrite", 32'(MemWrite), 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_data_in", data_in, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 16; i++)
      issue(1'b1, 2'd2, 1'b0, 6'(4 * i), $urandom);
    issue(1'b1, 2'd0, 1'b0, 6'd0, 32'h11);
    issue(1'b1, 2'd0, 1'b0, 6'd1, 32'h22);
    issue(1'b1, 2'd0, 1'b0, 6'd2, 32'h33);
    issue(1'b1, 2'd0, 1'b0, 6'd3, 32'h84);
    issue(1'b1, 2'd0, 1'b0, 6'd4, 32'h55);
    issue(1'b1, 2'd0, 1'b0, 6'd5, 32'h66);
    issue(1'b1, 2'd0, 1'b0, 6'd6, 32'h77);
    issue(1'b1, 2'd0, 1'b0, 6'd7, 32'h88);

    issue(1'b0, 2'd0, 1'b0, 6'd3, 32'd0);
    issue(1'b0, 2'd0, 1'b1, 6'd3, 32'd0);
    issue(1'b0, 2'd2, 1'b0, 6'd2, 32'd0);
    issue(1'b1, 2'd2, 1'b0, 6'd3, 32'hAABB_CCDD);
    issue(1'b0, 2'd2, 1'b0, 6'd0, 32'd0);
    issue(1'b0, 2'd2, 1'b0, 6'd4, 32'd0);
    issue(1'b1, 2'd0, 1'b0, 6'd63, 32'h9A);
    issue(1'b1, 2'd0, 1'b0, 6'd0, 32'h11);
    issue(1'b0, 2'd1, 1'b0, 6'd63, 32'd0);
    issue(1'b0, 2'd1, 1'b0, 6'd1, 32'd0);

`ifndef MISALIGN_TRAP_EN
    abort_store();
`endif
    issue(1'b0, 2'd2, 1'b0, 6'd4, 32'd0);
    issue(1'b0, 2'd2, 1'b0, 6'd0, 32'd0);
    issue(1'b0, 2'd3, 1'b0, 6'd5, 32'd0);
    issue(1'b1, 2'd3, 1'b0, 6'd8, 32'hDEAD_BEEF);
    issue(1'b0, 2'd2, 1'b0, 6'd1, 32'd0);

    for (int n = 0; n < 400; n++) begin
      bit [1:0] sz;
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      issue(1'($urandom), sz, 1'($urandom), 6'($urandom), $urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (3) begin @(posedge clk); #1; end
    chk("rsp_outstanding", 32'(exp_q.size()), 32'd0);
    chk("bus_outstanding", 32'(bus_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
